// File: rtl/pl_button_pkg.sv
// Shared types and defaults for the PL push-button reader.
package pl_button_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } btn_state_t;

   localparam int unsigned FCLK0_HZ      = 50000000;
   localparam int unsigned DEBOUNCE_20MS = FCLK0_HZ / 50;
   localparam int unsigned HOLD_1S       = FCLK0_HZ;

   // Counter width able to hold the larger cycle count itself (hold counter saturates there).
   function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
      int unsigned m;
      m = (a > b) ? a : b;
      if (m < 2) return 1;
      return $unsigned($clog2(m + 1));
   endfunction

endpackage

// File: rtl/pl_sync2.sv
// Generic two-flop synchronizer with configurable reset value.
module pl_sync2 #(
   parameter bit RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pl_button_reader.sv
// Debounces and classifies the MiniZed PL push-button (press/release/long-press events).
// Optional auto-repeat output enabled by defining PL_BTN_AUTOREPEAT_EN.
module pl_button_reader
   import pl_button_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_20MS,
   parameter int unsigned LONG_CYCLES     = HOLD_1S,
   parameter int unsigned ACTIVE_HIGH     = 1,
   parameter int unsigned CNT_W           = 8
`ifdef PL_BTN_AUTOREPEAT_EN
   ,
   parameter int unsigned REPEAT_CYCLES   = 12500000
`endif
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             btn_in,
   output logic             btn_level,
   output logic             press_pulse,
   output logic             release_pulse,
   output logic             long_press,
`ifdef PL_BTN_AUTOREPEAT_EN
   output logic             repeat_pulse,
`endif
   output logic [CNT_W-1:0] press_count
);

   localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES, LONG_CYCLES);
   localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
   localparam logic [CW-1:0] LONG_SAT  = CW'(LONG_CYCLES);

`ifdef PL_BTN_AUTOREPEAT_EN
   localparam int unsigned RW = cnt_width(REPEAT_CYCLES, REPEAT_CYCLES);
   localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
   logic [RW-1:0] rep_cnt;
`endif

   generate
      if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_params
         $error("pl_button_reader: need DEBOUNCE_CYCLES >= 2 and LONG_CYCLES > DEBOUNCE_CYCLES");
      end
   endgenerate

   btn_state_t    state;
   logic [CW-1:0] deb_cnt;
   logic [CW-1:0] hold_cnt;
   logic          raw;
   logic          s;

   // Polarity fix ahead of the synchronizer so both flops reset to "not pressed".
   assign raw = btn_in ^ (ACTIVE_HIGH == 0);

   pl_sync2 #(
      .RST_VAL (1'b0)
   ) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (raw),
      .q       (s)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         deb_cnt       <= '0;
         hold_cnt      <= '0;
         btn_level     <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         long_press    <= 1'b0;
         press_count   <= '0;
`ifdef PL_BTN_AUTOREPEAT_EN
         rep_cnt       <= '0;
         repeat_pulse  <= 1'b0;
`endif
      end else begin
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         long_press    <= 1'b0;
`ifdef PL_BTN_AUTOREPEAT_EN
         repeat_pulse  <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (s) begin
                  deb_cnt <= '0;
                  state   <= PRESS_WAIT;
               end
            end

            PRESS_WAIT: begin
               if (!s) begin
                  state <= IDLE;
               end else if (deb_cnt == DEB_LAST) begin
                  state       <= PRESSED;
                  press_pulse <= 1'b1;
                  btn_level   <= 1'b1;
                  press_count <= press_count + CNT_W'(1);
                  hold_cnt    <= '0;
`ifdef PL_BTN_AUTOREPEAT_EN
                  rep_cnt     <= '0;
`endif
               end else begin
                  deb_cnt <= deb_cnt + CW'(1);
               end
            end

            PRESSED: begin
               // Saturation at LONG_CYCLES makes LONG_LAST a once-per-press value.
               if (hold_cnt != LONG_SAT) hold_cnt <= hold_cnt + CW'(1);
               if (hold_cnt == LONG_LAST) long_press <= 1'b1;
`ifdef PL_BTN_AUTOREPEAT_EN
               if (hold_cnt == LONG_SAT) begin
                  if (rep_cnt == REP_LAST) begin
                     repeat_pulse <= 1'b1;
                     rep_cnt      <= '0;
                  end else begin
                     rep_cnt <= rep_cnt + RW'(1);
                  end
               end
`endif
               if (!s) begin
                  deb_cnt <= '0;
                  state   <= RELEASE_WAIT;
               end
            end

            RELEASE_WAIT: begin
               if (s) begin
                  state <= PRESSED;
               end else if (deb_cnt == DEB_LAST) begin
                  state         <= IDLE;
                  btn_level     <= 1'b0;
                  release_pulse <= 1'b1;
`ifdef PL_BTN_AUTOREPEAT_EN
                  rep_cnt       <= '0;
`endif
               end else begin
                  deb_cnt <= deb_cnt + CW'(1);
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pl_button_reader.sv
// Directed, table-driven bench for pl_button_reader (DEBOUNCE=8, LONG=40, CNT_W=3).
module tb_pl_button_reader;

   localparam int unsigned DEB = 8;
   localparam int unsigned LNG = 40;
   localparam int unsigned CW  = 3;
   localparam int unsigned REP = 10;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          btn_in;
   logic          btn_level;
   logic          press_pulse;
   logic          release_pulse;
   logic          long_press;
   logic [CW-1:0] press_count;
`ifdef PL_BTN_AUTOREPEAT_EN
   logic          repeat_pulse;
`endif

   always #5 clk = ~clk;

   pl_button_reader #(
      .DEBOUNCE_CYCLES (DEB),
      .LONG_CYCLES     (LNG),
      .ACTIVE_HIGH     (1),
      .CNT_W           (CW)
`ifdef PL_BTN_AUTOREPEAT_EN
      ,
      .REPEAT_CYCLES   (REP)
`endif
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .btn_in        (btn_in),
      .btn_level     (btn_level),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .long_press    (long_press),
`ifdef PL_BTN_AUTOREPEAT_EN
      .repeat_pulse  (repeat_pulse),
`endif
      .press_count   (press_count)
   );

   typedef struct {
      bit rst;
      bit btn;
      int cycles;
      int e_press;
      int e_release;
      int e_long;
      int e_level;
      int e_count;
   } row_t;

   row_t rows[$];
   int   checks = 0;
   int   errors = 0;
   int   press_n, release_n, long_n, repeat_n;
   int   press_at, release_at, long_at, rep_at0, rep_at1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual %0d required %0d", name, act, exp);
      end
   endtask

   task automatic add_row(input bit rst, input bit btn, input int cycles, input int ep,
                          input int er, input int el, input int elev, input int ecnt);
      row_t r;
      r.rst = rst; r.btn = btn; r.cycles = cycles;
      r.e_press = ep; r.e_release = er; r.e_long = el;
      r.e_level = elev; r.e_count = ecnt;
      rows.push_back(r);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Hold btn_in at b for n cycles, counting events and the cycle of their first occurrence.
   task automatic run_phase(input bit b, input int n);
      btn_in = b;
      press_n = 0; release_n = 0; long_n = 0; repeat_n = 0;
      press_at = -1; release_at = -1; long_at = -1; rep_at0 = -1; rep_at1 = -1;
      for (int c = 1; c <= n; c++) begin
         step();
         if (press_pulse) begin press_n++; if (press_at < 0) press_at = c; end
         if (release_pulse) begin release_n++; if (release_at < 0) release_at = c; end
         if (long_press) begin long_n++; if (long_at < 0) long_at = c; end
`ifdef PL_BTN_AUTOREPEAT_EN
         if (repeat_pulse) begin
            repeat_n++;
            if (rep_at0 < 0) rep_at0 = c; else if (rep_at1 < 0) rep_at1 = c;
         end
`endif
      end
   endtask

   task automatic do_reset();
      btn_in  = 1'b0;
      reset_n = 1'b0;
      step();
      step();
      check("rst_level", int'(btn_level), 0);
      check("rst_press", int'(press_pulse), 0);
      check("rst_release", int'(release_pulse), 0);
      check("rst_long", int'(long_press), 0);
      check("rst_count", int'(press_count), 0);
      reset_n = 1'b1;
      step();
      step();
   endtask

   // Event exclusivity and single-cycle width, checked every cycle out of reset.
   int   hot;
   logic prev_p = 1'b0, prev_r = 1'b0, prev_l = 1'b0;
   always @(negedge clk) begin
      if (reset_n === 1'b1) begin
         hot = int'(press_pulse) + int'(release_pulse) + int'(long_press);
         check("one_hot_events", (hot > 1) ? 1 : 0, 0);
         check("single_cycle_events",
               ((press_pulse && prev_p) || (release_pulse && prev_r) || (long_press && prev_l)) ? 1 : 0, 0);
      end
      prev_p = (reset_n === 1'b1) && press_pulse;
      prev_r = (reset_n === 1'b1) && release_pulse;
      prev_l = (reset_n === 1'b1) && long_press;
   end

   initial begin
      reset_n = 1'b0;
      btn_in  = 1'b0;

      add_row(1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         add_row(0, 1, 3, 0, 0, 0, 0, 0);
         add_row(0, 0, 3, 0, 0, 0, 0, 0);
      end
      add_row(0, 0, 10, 0, 0, 0, 0, 0);
      add_row(0, 1, 20, 1, 0, 0, 1, 1);
      add_row(0, 0, 20, 0, 1, 0, 0, 1);
      add_row(0, 1, 60, 1, 0, 1, 1, 2);
      add_row(0, 0, 20, 0, 1, 0, 0, 2);
      add_row(0, 1, 31, 1, 0, 0, 1, 3);
      add_row(0, 0, 4, 0, 0, 0, 1, 3);
      add_row(0, 1, 60, 0, 0, 1, 1, 3);
      add_row(0, 0, 20, 0, 1, 0, 0, 3);
      add_row(1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 1; i <= 9; i++) begin
         add_row(0, 1, 12, 1, 0, 0, 1, i % 8);
         add_row(0, 0, 12, 0, 1, 0, 0, i % 8);
      end

      foreach (rows[k]) begin
         if (rows[k].rst) begin
            do_reset();
         end else begin
            run_phase(rows[k].btn, rows[k].cycles);
            check($sformatf("row%0d_press", k), press_n, rows[k].e_press);
            check($sformatf("row%0d_release", k), release_n, rows[k].e_release);
            check($sformatf("row%0d_long", k), long_n, rows[k].e_long);
            check($sformatf("row%0d_level", k), int'(btn_level), rows[k].e_level);
            check($sformatf("row%0d_count", k), int'(press_count), rows[k].e_count);
         end
      end

      // Exact event latencies for a long press.
      do_reset();
      run_phase(1, 60);
      check("press_latency", press_at, 11);
      check("long_latency", long_at, 11 + 40);
      check("long_once", long_n, 1);
      run_phase(0, 20);
      check("release_latency", release_at, 11);

      // Asynchronous reset while held, then re-acceptance of the still-held button.
      run_phase(1, 20);
      check("held_level", int'(btn_level), 1);
      reset_n = 1'b0;
      #2;
      check("async_rst_level", int'(btn_level), 0);
      check("async_rst_count", int'(press_count), 0);
      check("async_rst_press", int'(press_pulse), 0);
      step();
      reset_n = 1'b1;
      run_phase(1, 20);
      check("reaccept_latency", press_at, 11);
      check("reaccept_press_n", press_n, 1);
      check("reaccept_count", int'(press_count), 1);
      run_phase(0, 20);
      check("reaccept_release", release_n, 1);

`ifdef PL_BTN_AUTOREPEAT_EN
      do_reset();
      run_phase(1, 75);
      check("repeat_n", repeat_n, 2);
      check("repeat_first", rep_at0 - long_at, 10);
      check("repeat_second", rep_at1 - long_at, 20);
      run_phase(0, 20);
      check("repeat_after_release", repeat_n, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
